maxpool1d: RTL and testbench

MAXPOOL1D -- requirements
Module: maxpool1d

---
 rtl/pool_pkg.sv | 15 +
 rtl/pool_lane.sv | 35 +++
 rtl/maxpool1d.sv | 118 +++++++++++
 tb/tb_maxpool1d.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling datapath.
// - pool_state_e : sequencing states of a pooling pass
// - FRAC_BITS    : fractional bits of the Q16.16 sample format
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    STORE,
    DONE
  } pool_state_e;

  localparam int FRAC_BITS = 16;

endpackage

// File: rtl/pool_lane.sv
// One channel of the max-pool datapath: a running-max register with a signed compare.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset, clears the running max
//   clear   - synchronous clear at the start of a pass
//   load    - take din unconditionally (first tap of a window)
//   cmp     - take din only if it is strictly greater (later taps)
//   din     - sample read for this channel this cycle
//   max_val - running max of the current window
module pool_lane
  import pool_pkg::*;
#(
  parameter int BITS = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               cmp,
  input  logic signed [BITS:0] din,
  output logic signed [BITS:0] max_val
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      max_val <= '0;
    end else if (load) begin
      max_val <= din;
    end else if (cmp && (din > max_val)) begin
      // Strictly greater: ties keep the earlier element.
      max_val <= din;
    end
  end

endmodule

// File: rtl/maxpool1d.sv
// 1-D max pooling over CH channels of a flat, channel-major Q16.16 feature map.
// A start pulse in IDLE runs one pass: for each output position, POOL SCAN cycles fold
// the window into per-channel running maxima, then one STORE cycle writes all channels.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset (aborts a pass, clears data_out)
//   start    - one-cycle pass request, honoured only in IDLE
//   data_in  - input map, ch0[0..IN_LEN-1], ch1[...], ...; held stable for the pass
//   data_out - pooled map, same channel-major layout, held between passes
//   busy     - high whenever a pass is in progress
//   done     - one-cycle pulse once data_out is complete
module maxpool1d
  import pool_pkg::*;
#(
  parameter int IN_LEN  = 780,
  parameter int CH      = 4,
  parameter int POOL    = 2,
  parameter int STRIDE  = 2,
  parameter int OUT_LEN = (IN_LEN - POOL) / STRIDE + 1,
  parameter int BITS    = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [BITS:0] data_in  [0:IN_LEN*CH-1],
  output logic signed [BITS:0] data_out [0:OUT_LEN*CH-1],
  output logic                busy,
  output logic                done
);

  localparam int PW = $clog2(OUT_LEN) + 1;
  localparam int TW = $clog2(POOL) + 1;
  localparam int IW = (IN_LEN * CH > 1) ? $clog2(IN_LEN * CH) : 1;
  localparam int OW = (OUT_LEN * CH > 1) ? $clog2(OUT_LEN * CH) : 1;

  localparam logic [PW-1:0] POS_LAST = PW'(OUT_LEN - 1);
  localparam logic [TW-1:0] TAP_LAST = TW'(POOL - 1);

  pool_state_e         state;
  logic [PW-1:0]       pos;
  logic [TW-1:0]       tap;
  logic                lane_clear;
  logic                lane_load;
  logic                lane_cmp;
  logic signed [BITS:0] lane_max [0:CH-1];

  assign lane_clear = (state == IDLE) && start;
  assign lane_load  = (state == SCAN) && (tap == '0);
  assign lane_cmp   = (state == SCAN) && (tap != '0);
  assign busy       = (state != IDLE);

  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic [IW-1:0] rd_idx;

    // Windows never run past IN_LEN, so trailing elements are never addressed.
    assign rd_idx = IW'(c * IN_LEN + int'(pos) * STRIDE + int'(tap));

    pool_lane #(
      .BITS(BITS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (lane_clear),
      .load   (lane_load),
      .cmp    (lane_cmp),
      .din    (data_in[rd_idx]),
      .max_val(lane_max[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pos   <= '0;
      tap   <= '0;
      done  <= 1'b0;
      for (int i = 0; i < OUT_LEN * CH; i++) begin
        data_out[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            pos   <= '0;
            tap   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (tap == TAP_LAST) begin
            tap   <= '0;
            state <= STORE;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        STORE: begin
          for (int c = 0; c < CH; c++) begin
            data_out[OW'(c * OUT_LEN + int'(pos))] <= lane_max[c];
          end
          if (pos == POS_LAST) begin
            state <= DONE;
          end else begin
            pos   <= pos + 1'b1;
            state <= SCAN;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool1d.sv
module tb_maxpool1d;

  localparam int IN_LEN = 8;
  localparam int CH     = 2;
  localparam int M_OUT  = 4;   // POOL=2, STRIDE=2
  localparam int C_OUT  = 8;   // POOL=1, STRIDE=1

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_m = 1'b0;
  logic start_c = 1'b0;
  logic signed [31:0] din    [0:IN_LEN*CH-1];
  logic signed [31:0] dout_m [0:M_OUT*CH-1];
  logic signed [31:0] dout_c [0:C_OUT*CH-1];
  logic busy_m, done_m, busy_c, done_c;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int                 due_m[$];
  logic signed [31:0] val_m[$];
  int                 due_c[$];
  logic signed [31:0] val_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool1d #(
    .IN_LEN(IN_LEN), .CH(CH), .POOL(2), .STRIDE(2), .OUT_LEN(M_OUT), .BITS(31)
  ) u_main (
    .clk(clk), .rst(rst), .start(start_m), .data_in(din), .data_out(dout_m),
    .busy(busy_m), .done(done_m)
  );

  maxpool1d #(
    .IN_LEN(IN_LEN), .CH(CH), .POOL(1), .STRIDE(1), .OUT_LEN(C_OUT), .BITS(31)
  ) u_copy (
    .clk(clk), .rst(rst), .start(start_c), .data_in(din), .data_out(dout_c),
    .busy(busy_c), .done(done_c)
  );

  // Reference: maximum of a window of the current input map.
  function automatic logic signed [31:0] win_max(input int base, input int pool);
    logic signed [31:0] m;
    m = din[base];
    for (int k = 1; k < pool; k++) begin
      if (din[base + k] > m) m = din[base + k];
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Issue a start; the pass that E0 (next edge) launches is expected to finish
  // OUT_LEN*(POOL+1)+1 edges after E0.
  task automatic go_main();
    due_m.push_back(cyc + 1 + M_OUT * 3 + 1);
    for (int c = 0; c < CH; c++)
      for (int o = 0; o < M_OUT; o++) val_m.push_back(win_max(c * IN_LEN + o * 2, 2));
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    check("main_busy_after_start", 32'(busy_m), 32'd1);
  endtask

  task automatic go_copy();
    due_c.push_back(cyc + 1 + C_OUT * 2 + 1);
    for (int c = 0; c < CH; c++)
      for (int o = 0; o < C_OUT; o++) val_c.push_back(win_max(c * IN_LEN + o, 1));
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("copy_busy_after_start", 32'(busy_c), 32'd1);
  endtask

  task automatic wait_main_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_m) return;
    end
    checks++;
    errors++;
    $display("FAIL main_done_timeout actual=no_done required=done_within_%0d", budget);
  endtask

  task automatic wait_copy_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_c) return;
    end
    checks++;
    errors++;
    $display("FAIL copy_done_timeout actual=no_done required=done_within_%0d", budget);
  endtask

  task automatic load_scaled(input int v[16]);
    for (int i = 0; i < 16; i++) din[i] = 32'(v[i] * 65536);
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) begin
      // Small values make ties and sign mixes frequent.
      if ($urandom_range(0, 1) == 0) din[i] = 32'($signed($urandom_range(0, 6)) - 3) <<< 16;
      else din[i] = 32'($urandom);
    end
  endtask

  // Monitors: pop the scoreboard whenever a DUT pulses done.
  always @(posedge clk) begin
    int due;
    #1;
    if (done_m) begin
      checks++;
      if (due_m.size() == 0) begin
        errors++;
        $display("FAIL main_done_unexpected actual=done_at_%0d required=no_done", cyc);
      end else begin
        due = due_m.pop_front();
        if (cyc != due) begin
          errors++;
          $display("FAIL main_done_time actual=%0d required=%0d", cyc, due);
        end
        for (int i = 0; i < M_OUT * CH; i++) check("main_data_out", dout_m[i], val_m.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    int due;
    #1;
    if (done_c) begin
      checks++;
      if (due_c.size() == 0) begin
        errors++;
        $display("FAIL copy_done_unexpected actual=done_at_%0d required=no_done", cyc);
      end else begin
        due = due_c.pop_front();
        if (cyc != due) begin
          errors++;
          $display("FAIL copy_done_time actual=%0d required=%0d", cyc, due);
        end
        for (int i = 0; i < C_OUT * CH; i++) check("copy_data_out", dout_c[i], val_c.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int basic[16] = '{1, 3, 2, 2, -1, -4, 5, 0, -2, -1, -3, -3, 7, 7, 0, -8};
    logic signed [31:0] basic_exp[8] = '{32'sh30000, 32'sh20000, -32'sh10000, 32'sh50000,
                                         -32'sh10000, -32'sh30000, 32'sh70000, 32'sh0};
    int gap;
    int extra;

    for (int i = 0; i < 16; i++) din[i] = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(busy_m), 32'd0);
    check("reset_done", 32'(done_m), 32'd0);
    for (int i = 0; i < M_OUT * CH; i++) check("reset_data_out", dout_m[i], 32'sd0);

    // Basic pass, also checked against the literal expected map.
    load_scaled(basic);
    go_main();
    wait_main_done(40);
    for (int i = 0; i < 8; i++) check("basic_literal", dout_m[i], basic_exp[i]);

    // All negative, one slightly larger element: no zero seed, signed compare.
    tick();
    for (int i = 0; i < 16; i++) din[i] = -32'sh10000;
    din[5] = -32'sh8000;
    go_main();
    wait_main_done(40);
    check("neg_literal_2", dout_m[2], -32'sh8000);
    check("neg_literal_0", dout_m[0], -32'sh10000);

    // Second start four cycles after the first must be ignored.
    tick();
    load_scaled(basic);
    go_main();
    repeat (3) tick();
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    wait_main_done(40);
    repeat (20) tick();

    // Reset at cycle 6 of a pass aborts it.
    go_main();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(due_m.pop_back());
    for (int i = 0; i < M_OUT * CH; i++) void'(val_m.pop_back());
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_done", 32'(done_m), 32'd0);
    for (int i = 0; i < M_OUT * CH; i++) check("abort_data_out", dout_m[i], 32'sd0);
    repeat (20) tick();
    check("abort_no_done", 32'(done_m), 32'd0);
    go_main();
    wait_main_done(40);

    // Back-to-back: restart one cycle after done with new data.
    load_random();
    go_main();
    wait_main_done(40);
    load_random();
    go_main();
    wait_main_done(40);

    // Randomized passes, some with an ignored start while busy.
    for (int n = 0; n < 16; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      load_random();
      go_main();
      if ($urandom_range(0, 1) == 1) begin
        extra = $urandom_range(0, 10);
        repeat (extra) tick();
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
      end
      wait_main_done(40);
    end

    // Copy mode.
    for (int n = 0; n < 3; n++) begin
      tick();
      if (n == 0) load_scaled(basic);
      else load_random();
      go_copy();
      wait_copy_done(60);
    end

    repeat (30) tick();
    check("main_scoreboard_drained", 32'(due_m.size()), 32'd0);
    check("copy_scoreboard_drained", 32'(due_c.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
